data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a byte-enabled word memory
// with configurable read latency and held-until-accepted responses.
module data_mem_responder #(
    parameter int XLEN         = 32,
    parameter int DATA_WIDTH   = 3,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0] req_width,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_write
);
    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH-1:0] W_WORD = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] W_HALF = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] W_BYTE = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] W_BYTEU = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] W_HALFU = DATA_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d, wr_q, wr_d;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [1:0]      lane;
    logic [XLEN-1:0] widx, wsh, rsh, ld;
    logic [NB-1:0]   be;
    logic            is_word, is_half, is_byte, err, accept;

    assign lane    = req_addr[1:0];
    assign widx    = req_addr >> 2;
    assign is_word = req_width == W_WORD;
    assign is_half = req_width == W_HALF || req_width == W_HALFU;
    assign is_byte = req_width == W_BYTE || req_width == W_BYTEU;
    assign err     = !(is_word || is_half || is_byte)
                   || (req_write && (req_width == W_BYTEU || req_width == W_HALFU))
                   || (is_half && lane[0]) || (is_word && lane != 2'd0)
                   || (widx >= XLEN'(DEPTH_WORDS));
    assign accept  = req_valid && state_q == IDLE;
    assign wsh     = req_wdata << {lane, 3'b000};
    assign be      = is_word ? '1 : is_half ? NB'(3) << lane : NB'(1) << lane;
    // Read happens at accept: no store can land while a load is outstanding.
    assign rsh     = mem[widx[AW-1:0]] >> {lane, 3'b000};
    assign ld      = is_word ? rsh : is_half ? XLEN'(rsh[15:0]) : XLEN'(rsh[7:0]);

    always_ff @(posedge clk) begin
        if (accept && req_write && !err)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wsh[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_d    = wr_q;
        if (accept) begin
            err_d   = err;
            wr_d    = req_write;
            rdata_d = (err || req_write) ? '0 : ld;
            cnt_d   = 3'(READ_LATENCY - 2);
            state_d = (err || req_write || READ_LATENCY == 1) ? RESP : READ_WAIT;
        end else if (state_q == READ_WAIT) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q == 3'd0 ? RESP : READ_WAIT;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_error = rsp_valid && err_q;
    assign rsp_write = rsp_valid && wr_q;
endmodule
